maxpool_flatten_collector: RTL and testbench

//  Consumer side of the 16-channel max-pooling stream. Captures each pooled beat (valid_in + one bit/channel)

---
 rtl/maxpool_flatten_collector.sv | 159 +++++++++++++++
 tb/tb_maxpool_flatten_collector.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_flatten_collector.sv
// Flattens the pooled 16-channel beat stream into one frame for the FC layer.
// Define MAXPOOL_COLLECT_DOUBLE_BUF_EN for a ping-pong pair of frame banks.
module maxpool_flatten_collector #(
    parameter  int CHANNELS   = 16,
    parameter  int OUT_WIDTH  = 5,
    parameter  int OUT_HEIGHT = 5,
    localparam int NPIX       = OUT_WIDTH * OUT_HEIGHT,
    localparam int FRAME_BITS = CHANNELS * NPIX,
    localparam int CW         = $clog2(NPIX + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [CHANNELS-1:0]   pixel_in,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic [CW-1:0]         fill_count,
    output logic                  overflow
);

    logic [CW-1:0] fill_q;
    logic          ovf_q;
    logic          we;
    logic          last;

    assign last       = (fill_q == CW'(NPIX - 1));
    assign fill_count = fill_q;
    assign overflow   = ovf_q;

`ifdef MAXPOOL_COLLECT_DOUBLE_BUF_EN

    logic [FRAME_BITS-1:0] bank_q [2];
    logic [FRAME_BITS-1:0] bank_d [2];
    logic [1:0]            full_q;
    logic [1:0]            full_d;
    logic                  wr_q;
    logic                  rd_q;
    logic                  xfer;
    logic                  space;

    assign frame_valid = full_q[rd_q];
    assign frame_data  = bank_q[rd_q];
    assign xfer        = full_q[rd_q] && frame_ready;
    // The write bank may be the one leaving this very cycle.
    assign space       = !full_q[wr_q] || (xfer && (rd_q == wr_q));
    assign we          = valid_in && space;

    always_comb begin
        bank_d = bank_q;
        full_d = full_q;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int p = 0; p < NPIX; p++) begin
                if (we && fill_q == CW'(p)) begin
                    bank_d[wr_q][c*NPIX+p] = pixel_in[c];
                end
            end
        end
        if (xfer) begin
            full_d[rd_q] = 1'b0;
        end
        if (we && last) begin
            full_d[wr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            fill_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            bank_q <= bank_d;
            full_q <= full_d;
            if (xfer) begin
                rd_q <= ~rd_q;
            end
            if (we) begin
                if (last) begin
                    fill_q <= '0;
                    wr_q   <= ~wr_q;
                end else begin
                    fill_q <= fill_q + CW'(1);
                end
            end else if (valid_in) begin
                ovf_q <= 1'b1;
            end
        end
    end

`else

    typedef enum logic {
        FILL,
        HOLD
    } state_e;

    state_e                state_q;
    logic [FRAME_BITS-1:0] buf_q;
    logic [FRAME_BITS-1:0] buf_d;
    logic                  fv_q;

    assign frame_valid = fv_q;
    assign frame_data  = buf_q;
    // In HOLD a beat is only accepted alongside the transfer.
    assign we = valid_in && ((state_q == FILL) || frame_ready);

    always_comb begin
        buf_d = buf_q;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int p = 0; p < NPIX; p++) begin
                if (we && fill_q == CW'(p)) begin
                    buf_d[c*NPIX+p] = pixel_in[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            buf_q   <= '0;
            fill_q  <= '0;
            fv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            buf_q <= buf_d;
            unique case (state_q)
                FILL: begin
                    if (valid_in) begin
                        if (last) begin
                            fill_q  <= '0;
                            fv_q    <= 1'b1;
                            state_q <= HOLD;
                        end else begin
                            fill_q <= fill_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (fv_q && frame_ready) begin
                        fv_q    <= 1'b0;
                        state_q <= FILL;
                        fill_q  <= valid_in ? CW'(1) : '0;
                    end else if (valid_in) begin
                        ovf_q <= 1'b1;
                    end
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_maxpool_flatten_collector.sv
// Scoreboard bench for maxpool_flatten_collector: frames are queued as
// their last beat is driven and checked when the FC side accepts them.
module tb_maxpool_flatten_collector;

    localparam int CH   = 16;
    localparam int NPIX = 25;
    localparam int FB   = CH * NPIX;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic [CH-1:0] pixel_in = '0;
    logic          frame_ready = 1'b0;
    logic          frame_valid;
    logic [FB-1:0] frame_data;
    logic [CW-1:0] fill_count;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    logic [FB-1:0] exp_q[$];
    logic [FB-1:0] cur = '0;
    int            tb_fill = 0;

    maxpool_flatten_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .pixel_in    (pixel_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .fill_count  (fill_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [FB-1:0] e;
        if (rst_n && frame_valid && frame_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got frame %h, required none", frame_data);
            end else begin
                e = exp_q.pop_front();
                if (frame_data !== e) begin
                    errors++;
                    $display("FAIL xfer_data: got %h required %h", frame_data, e);
                end
            end
        end
    end

    task automatic beat(input logic [CH-1:0] p, input bit acc);
        valid_in = 1'b1;
        pixel_in = p;
        @(posedge clk);
        if (acc) begin
            for (int c = 0; c < CH; c++) cur[c*NPIX+tb_fill] = p[c];
            tb_fill++;
            if (tb_fill == NPIX) begin
                exp_q.push_back(cur);
                tb_fill = 0;
            end
        end
        #1 valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xfer();
        frame_ready = 1'b1;
        @(posedge clk);
        #1 frame_ready = 1'b0;
    endtask

    task automatic rand_beats(input int n);
        for (int i = 0; i < n; i++) beat(CH'($urandom), 1'b1);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (frame_valid !== 1'b0 || overflow !== 1'b0 || fill_count !== '0 || frame_data !== '0) begin
            errors++;
            $display("FAIL reset: got v=%b o=%b f=%0d d=%h required all zero",
                     frame_valid, overflow, fill_count, frame_data);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_capture();
        logic [FB-1:0] ref_f;
        logic [CH-1:0] v;
        for (int p = 0; p < NPIX; p++) begin
            v = CH'(1) << (p % 16);
            beat(v, 1'b1);
            if (p == NPIX - 2) begin
                chk("cap_fill24", 32'(fill_count), 32'd24);
                chk("cap_valid_early", 32'(frame_valid), 32'd0);
            end
        end
        chk("cap_valid", 32'(frame_valid), 32'd1);
        chk("cap_fill_wrap", 32'(fill_count), 32'd0);
        for (int c = 0; c < CH; c++)
            for (int p = 0; p < NPIX; p++)
                ref_f[c*NPIX+p] = (c == p % 16);
        checks++;
        if (frame_data !== ref_f) begin
            errors++;
            $display("FAIL cap_onehot: got %h required %h", frame_data, ref_f);
        end
    endtask

    task automatic test_hold_stable();
        logic [FB-1:0] snap;
        snap = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            idle(1);
            checks++;
            if (frame_valid !== 1'b1 || frame_data !== snap) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d got v=%b d=%h required v=1 d=%h",
                         i, frame_valid, frame_data, snap);
            end
        end
        xfer();
        chk("hold_drop", 32'(frame_valid), 32'd0);
    endtask

    task automatic test_simultaneous();
        rand_beats(NPIX);
        chk("sim_hold", 32'(frame_valid), 32'd1);
        frame_ready = 1'b1;
        beat(CH'($urandom), 1'b1);
        frame_ready = 1'b0;
        chk("sim_fill1", 32'(fill_count), 32'd1);
        chk("sim_drop", 32'(frame_valid), 32'd0);
        rand_beats(NPIX - 2);
        chk("sim_fill24", 32'(fill_count), 32'd24);
        chk("sim_notyet", 32'(frame_valid), 32'd0);
        rand_beats(1);
        chk("sim_valid", 32'(frame_valid), 32'd1);
        xfer();
        chk("sim_done", 32'(frame_valid), 32'd0);
    endtask

`ifdef MAXPOOL_COLLECT_DOUBLE_BUF_EN
    task automatic test_double();
        rand_beats(2 * NPIX);
        chk("dbl_no_ovf", 32'(overflow), 32'd0);
        chk("dbl_valid", 32'(frame_valid), 32'd1);
        chk("dbl_fill", 32'(fill_count), 32'd0);
        beat(CH'($urandom), 1'b0);
        chk("dbl_ovf", 32'(overflow), 32'd1);
        chk("dbl_ovf_fill", 32'(fill_count), 32'd0);
        frame_ready = 1'b1;
        idle(2);
        frame_ready = 1'b0;
        chk("dbl_empty", 32'(frame_valid), 32'd0);
    endtask
`else
    task automatic test_overflow();
        rand_beats(NPIX);
        beat(CH'($urandom), 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_fill", 32'(fill_count), 32'd0);
        chk("ovf_hold", 32'(frame_valid), 32'd1);
        idle(3);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        xfer();
        rand_beats(NPIX - 1);
        chk("ovf_next_early", 32'(frame_valid), 32'd0);
        rand_beats(1);
        chk("ovf_next_valid", 32'(frame_valid), 32'd1);
        xfer();
        chk("ovf_still", 32'(overflow), 32'd1);
    endtask
`endif

    task automatic test_reset_mid();
        rand_beats(12);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (frame_valid !== 1'b0 || overflow !== 1'b0 || fill_count !== '0 || frame_data !== '0) begin
            errors++;
            $display("FAIL rst_mid: got v=%b o=%b f=%0d required all zero",
                     frame_valid, overflow, fill_count);
        end
        tb_fill = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rand_beats(NPIX - 1);
        chk("rst_fresh_early", 32'(frame_valid), 32'd0);
        rand_beats(1);
        chk("rst_fresh_valid", 32'(frame_valid), 32'd1);
        xfer();
        chk("rst_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        test_reset();
        test_capture();
        test_hold_stable();
        test_simultaneous();
`ifdef MAXPOOL_COLLECT_DOUBLE_BUF_EN
        test_double();
`else
        test_overflow();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
